// File: rtl/act_vector_loader_pkg.sv
// Shared defaults, output-side state encoding and bus packing helper for the
// activation vector loader.
package act_vector_loader_pkg;

  localparam int DATA_W_DEF      = 8;
  localparam int N_IN_DEF        = 15;
  localparam int HOLD_CYCLES_DEF = 3;

  typedef enum logic {
    OUT_IDLE = 1'b0,
    OUT_HOLD = 1'b1
  } out_state_e;

  // Bit offset of element idx on the parallel activation bus.
  function automatic int elem_offset(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/act_hold_timer.sv
// Loadable down-counter that spans the node pipeline latency: load starts a
// hold, expire pulses for one cycle when the node outputs become valid.
module act_hold_timer
  import act_vector_loader_pkg::*;
#(
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic busy,
  output logic swap_ok,
  output logic expire
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);

  out_state_e      state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic            expire_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= OUT_IDLE;
      count_q <= '0;
      expire  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      expire  <= expire_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    expire_d = 1'b0;
    case (state_q)
      OUT_IDLE: begin
        if (load) begin
          state_d = OUT_HOLD;
          count_d = CW'(HOLD_CYCLES);
        end
      end
      OUT_HOLD: begin
        count_d = count_q - CW'(1);
        // Last decrement: outputs are valid in the cycle after this edge.
        if (count_q == CW'(1)) begin
          state_d  = OUT_IDLE;
          expire_d = 1'b1;
        end
      end
      default: state_d = OUT_IDLE;
    endcase
  end

  assign busy    = (state_q == OUT_HOLD);
  assign swap_ok = (state_q == OUT_IDLE);

endmodule

// File: rtl/act_vector_loader.sv
// Serial-to-parallel activation feeder: fills one vector while the previous
// one is held stable on a_bus for the node pipeline latency.
module act_vector_loader
  import act_vector_loader_pkg::*;
#(
  parameter int N_IN        = N_IN_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        s_data,
  input  logic                     s_valid,
  input  logic                     s_last,
  output logic                     s_ready,
  output logic [N_IN*DATA_W-1:0]   a_bus,
  output logic                     vec_valid,
  output logic                     res_valid,
  output logic                     len_err,
  output logic                     out_state
);

  localparam int             IW       = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [IW-1:0]  LAST_IDX = IW'(N_IN - 1);

  // Handshake: a beat transfers on a rising edge where s_valid and s_ready
  // are both high; s_ready comes straight from a flop and never looks at s_valid.
  logic [N_IN*DATA_W-1:0] fill_q;
  logic [IW-1:0]          idx_q;
  logic                   fill_full_q;
  logic                   accept, vec_end, swap, swap_ok, busy;

  assign s_ready = ~fill_full_q;
  assign accept  = s_valid & s_ready;
  assign vec_end = s_last | (idx_q == LAST_IDX);
  assign swap    = fill_full_q & swap_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_q      <= '0;
      idx_q       <= '0;
      fill_full_q <= 1'b0;
      a_bus       <= '0;
      vec_valid   <= 1'b0;
      len_err     <= 1'b0;
    end else begin
      vec_valid <= 1'b0;
      len_err   <= 1'b0;
      if (accept) begin
        for (int i = 0; i < N_IN; i++) begin
          if (IW'(i) == idx_q)
            fill_q[elem_offset(i, DATA_W) +: DATA_W] <= s_data;
          else if (s_last && (IW'(i) > idx_q))
            fill_q[elem_offset(i, DATA_W) +: DATA_W] <= '0;
        end
        if (vec_end) begin
          fill_full_q <= 1'b1;
          idx_q       <= '0;
          // Early s_last or a missing one both close the vector but flag it.
          len_err     <= (idx_q != LAST_IDX) | ~s_last;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
      // accept needs fill_full_q low and swap needs it high, so they never collide.
      if (swap) begin
        a_bus       <= fill_q;
        fill_full_q <= 1'b0;
        vec_valid   <= 1'b1;
      end
    end
  end

  act_hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (swap),
    .busy    (busy),
    .swap_ok (swap_ok),
    .expire  (res_valid)
  );

  assign out_state = busy;

endmodule

// File: tb/tb_act_vector_loader.sv
// Bench for act_vector_loader: randomized streams against a vector-level
// reference model, with a second instance built for a long node latency.
module tb_act_vector_loader;

  localparam int N  = 15;
  localparam int W  = 8;
  localparam int BW = N * W;
  localparam int H1 = 3;
  localparam int H2 = 20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0]  s_data;
  logic          s_valid, s_last;
  logic          s_ready1, vec_valid1, res_valid1, len_err1, out_state1;
  logic          s_ready2, vec_valid2, res_valid2, len_err2, out_state2;
  logic [BW-1:0] a_bus1, a_bus2;

  act_vector_loader #(.N_IN(N), .DATA_W(W), .HOLD_CYCLES(H1)) dut1 (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready1), .a_bus(a_bus1), .vec_valid(vec_valid1), .res_valid(res_valid1),
    .len_err(len_err1), .out_state(out_state1));

  act_vector_loader #(.N_IN(N), .DATA_W(W), .HOLD_CYCLES(H2)) dut2 (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready2), .a_bus(a_bus2), .vec_valid(vec_valid2), .res_valid(res_valid2),
    .len_err(len_err2), .out_state(out_state2));

  int n_checks = 0;
  int n_fail   = 0;
  bit sel      = 1'b0;

  logic          m_vv, m_rv, m_le;
  logic [BW-1:0] m_bus;
  assign m_vv  = sel ? vec_valid2 : vec_valid1;
  assign m_rv  = sel ? res_valid2 : res_valid1;
  assign m_le  = sel ? len_err2   : len_err1;
  assign m_bus = sel ? a_bus2     : a_bus1;

  // ---------------- scoreboard state ----------------
  logic [W-1:0]  bd_q[$];
  bit            bl_q[$];
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] got_q[$];
  int            end_idx_q[$], beat_acc_q[$], exp_vv_q[$], vv_q[$], rv_q[$];
  int            exp_err, len_cnt, stab_err;
  logic [BW-1:0] prev_bus;

  // Monitor: any bus change not announced by vec_valid is a stability breach.
  always @(negedge clk) begin
    if (!reset) begin
      prev_bus = '0;
    end else begin
      if (m_vv) begin
        got_q.push_back(m_bus);
        vv_q.push_back(cyc);
      end else if (m_bus !== prev_bus) begin
        stab_err = stab_err + 1;
      end
      if (m_rv) rv_q.push_back(cyc);
      if (m_le) len_cnt = len_cnt + 1;
      prev_bus = m_bus;
    end
  end

  // ---------------- reference model ----------------
  task automatic build_model();
    logic [BW-1:0] cur;
    int n;
    exp_q.delete(); end_idx_q.delete(); exp_err = 0;
    cur = '0; n = 0;
    for (int k = 0; k < bd_q.size(); k++) begin
      cur[n*W +: W] = bd_q[k];
      n++;
      if (bl_q[k] || n == N) begin
        if (!(bl_q[k] && n == N)) exp_err++;
        exp_q.push_back(cur);
        end_idx_q.push_back(k);
        cur = '0; n = 0;
      end
    end
  endtask

  // A vector reaches the bus one edge after its last beat, but never sooner
  // than h+1 edges after the previous vector did.
  task automatic calc_times(input int h);
    int e, prev;
    exp_vv_q.delete(); prev = -1000;
    for (int k = 0; k < end_idx_q.size(); k++) begin
      e = (end_idx_q[k] < beat_acc_q.size()) ? beat_acc_q[end_idx_q[k]] + 1 : -1;
      if (prev + h + 1 > e) e = prev + h + 1;
      exp_vv_q.push_back(e);
      prev = e;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic clear_obs();
    got_q.delete(); vv_q.delete(); rv_q.delete();
    len_cnt = 0; stab_err = 0; prev_bus = m_bus;
  endtask

  task automatic reset_dut();
    s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #1;
    clear_obs();
  endtask

  task automatic new_stream();
    bd_q.delete(); bl_q.delete();
  endtask

  task automatic drive_beats(input int gap_max, output bit to);
    bit rdy, done;
    int a, gap;
    to = 1'b0; beat_acc_q.delete();
    for (int k = 0; k < bd_q.size(); k++) begin
      gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      s_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      s_valid = 1'b1; s_data = bd_q[k]; s_last = bl_q[k];
      done = 1'b0;
      for (int t = 0; t < 100 && !done; t++) begin
        @(negedge clk);
        rdy = sel ? s_ready2 : s_ready1;
        a   = cyc + 1;
        @(posedge clk); #1;
        if (rdy) begin done = 1'b1; beat_acc_q.push_back(a); end
      end
      if (!done) begin to = 1'b1; break; end
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_done(input int h, output bit to);
    to = 1'b1;
    for (int t = 0; t < 2000; t++) begin
      if (vv_q.size() >= exp_q.size() && rv_q.size() >= exp_q.size()) begin
        to = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    repeat (h + 3) begin @(posedge clk); #1; end
  endtask

  task automatic run_stream(input int gap_max, input int h, output bit to);
    bit t1, t2;
    build_model();
    drive_beats(gap_max, t1);
    wait_done(h, t2);
    calc_times(h);
    to = t1 | t2;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    #1;
    n_checks++; if (a_bus1 !== '0 || a_bus2 !== '0) begin n_fail++; $display("FAIL reset_bus: got %h / %h required 0", a_bus1, a_bus2); end
    n_checks++; if ({vec_valid1, res_valid1, len_err1} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses: got %b required 000", {vec_valid1, res_valid1, len_err1}); end
    n_checks++; if (s_ready1 !== 1'b1 || s_ready2 !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b%b required 11", s_ready1, s_ready2); end
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #1;
    n_checks++; if ({s_ready1, out_state1, vec_valid1, res_valid1} !== 4'b1000) begin n_fail++; $display("FAIL reset_release: got %b required 1000", {s_ready1, out_state1, vec_valid1, res_valid1}); end
    clear_obs();
  endtask

  task automatic test_basic();
    bit to;
    sel = 1'b0; reset_dut(); new_stream();
    for (int i = 1; i <= N; i++) begin bd_q.push_back(W'(i)); bl_q.push_back(i == N); end
    build_model();
    drive_beats(0, to);
    n_checks++; if (s_ready1 !== 1'b0) begin n_fail++; $display("FAIL basic_ready_low: got %b required 0", s_ready1); end
    wait_done(H1, to); calc_times(H1);
    n_checks++; if (to || got_q.size() != 1 || rv_q.size() != 1) begin n_fail++; $display("FAIL basic_count: got %0d vectors %0d results required 1 1", got_q.size(), rv_q.size()); end
    else begin
      n_checks++; if (got_q[0][7:0] !== 8'd1 || got_q[0][119:112] !== 8'd15) begin n_fail++; $display("FAIL basic_ends: got %0d..%0d required 1..15", got_q[0][7:0], got_q[0][119:112]); end
      n_checks++; if (got_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL basic_vector: got %h required %h", got_q[0], exp_q[0]); end
      n_checks++; if (vv_q[0] != beat_acc_q[N-1] + 1) begin n_fail++; $display("FAIL basic_vv_latency: got %0d required %0d", vv_q[0], beat_acc_q[N-1] + 1); end
      n_checks++; if (rv_q[0] != vv_q[0] + H1) begin n_fail++; $display("FAIL basic_rv_latency: got %0d required %0d", rv_q[0], vv_q[0] + H1); end
    end
    n_checks++; if (len_cnt != 0 || stab_err != 0) begin n_fail++; $display("FAIL basic_err: got len %0d stab %0d required 0 0", len_cnt, stab_err); end
  endtask

  task automatic test_short_vector();
    bit to;
    sel = 1'b0; reset_dut(); new_stream();
    bd_q = '{8'h80, 8'h7f, 8'hff}; bl_q = '{1'b0, 1'b0, 1'b1};
    run_stream(0, H1, to);
    n_checks++; if (to || got_q.size() != 1) begin n_fail++; $display("FAIL short_count: got %0d required 1", got_q.size()); end
    else begin
      n_checks++; if (got_q[0][23:0] !== 24'hff7f80) begin n_fail++; $display("FAIL short_head: got %h required ff7f80", got_q[0][23:0]); end
      n_checks++; if (got_q[0][BW-1:24] !== '0) begin n_fail++; $display("FAIL short_pad: got %h required 0", got_q[0][BW-1:24]); end
    end
    n_checks++; if (len_cnt != 1 || len_cnt != exp_err) begin n_fail++; $display("FAIL short_len_err: got %0d required 1", len_cnt); end
  endtask

  task automatic test_back_to_back(input bit long_hold);
    bit to;
    int h;
    h = long_hold ? H2 : H1;
    sel = long_hold; reset_dut(); new_stream();
    for (int i = 0; i < 2 * N; i++) begin bd_q.push_back(W'($urandom_range(0, 255))); bl_q.push_back(i == N - 1 || i == 2 * N - 1); end
    run_stream(0, h, to);
    n_checks++; if (to || got_q.size() != 2 || rv_q.size() != 2) begin n_fail++; $display("FAIL b2b_count h=%0d: got %0d required 2", h, got_q.size()); end
    else begin
      n_checks++; if (vv_q[1] - vv_q[0] != (long_hold ? H2 + 1 : N + 1)) begin n_fail++; $display("FAIL b2b_spacing h=%0d: got %0d required %0d", h, vv_q[1] - vv_q[0], long_hold ? H2 + 1 : N + 1); end
      for (int k = 0; k < 2; k++) begin
        n_checks++; if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL b2b_vector%0d h=%0d: got %h required %h", k, h, got_q[k], exp_q[k]); end
        n_checks++; if (rv_q[k] != vv_q[k] + h) begin n_fail++; $display("FAIL b2b_rv%0d h=%0d: got %0d required %0d", k, h, rv_q[k], vv_q[k] + h); end
      end
      if (long_hold) begin
        n_checks++; if (vv_q[1] <= beat_acc_q[2*N-1] + 1) begin n_fail++; $display("FAIL b2b_stall: got swap %0d required after %0d", vv_q[1], beat_acc_q[2*N-1] + 1); end
      end
    end
    n_checks++; if (stab_err != 0 || len_cnt != 0) begin n_fail++; $display("FAIL b2b_stable h=%0d: got stab %0d len %0d required 0 0", h, stab_err, len_cnt); end
  endtask

  task automatic test_missing_last();
    bit to;
    sel = 1'b0; reset_dut(); new_stream();
    for (int i = 0; i < 2 * N; i++) begin bd_q.push_back(W'($urandom_range(0, 255))); bl_q.push_back(i == 2 * N - 1); end
    run_stream(0, H1, to);
    n_checks++; if (to || got_q.size() != 2) begin n_fail++; $display("FAIL nolast_count: got %0d required 2", got_q.size()); end
    else begin
      n_checks++; if (got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin n_fail++; $display("FAIL nolast_vectors: got %h required %h", got_q[1], exp_q[1]); end
    end
    n_checks++; if (len_cnt != exp_err || exp_err != 1) begin n_fail++; $display("FAIL nolast_len_err: got %0d required 1", len_cnt); end
  endtask

  task automatic test_async_reset();
    bit to;
    sel = 1'b0; reset_dut(); new_stream();
    for (int i = 0; i < 7; i++) begin bd_q.push_back(W'($urandom_range(1, 255))); bl_q.push_back(1'b0); end
    build_model(); drive_beats(0, to);
    #2 reset = 1'b0;
    #1;
    n_checks++; if ({s_ready1, out_state1, vec_valid1, len_err1} !== 4'b1000 || a_bus1 !== '0) begin n_fail++; $display("FAIL arst_fill: got %b bus %h required 1000 bus 0", {s_ready1, out_state1, vec_valid1, len_err1}, a_bus1); end
    @(posedge clk); #3 reset = 1'b1; clear_obs();
    new_stream();
    for (int i = 0; i < N; i++) begin bd_q.push_back(W'($urandom_range(1, 255))); bl_q.push_back(i == N - 1); end
    drive_beats(0, to);
    for (int t = 0; t < 50 && vv_q.size() == 0; t++) begin @(posedge clk); #1; end
    build_model();
    n_checks++; if (vv_q.size() != 1 || a_bus1 !== exp_q[0]) begin n_fail++; $display("FAIL arst_after_fill: got %h required %h", a_bus1, exp_q[0]); end
    #2 reset = 1'b0;
    #1;
    n_checks++; if (a_bus1 !== '0 || {s_ready1, out_state1, vec_valid1, res_valid1} !== 4'b1000) begin n_fail++; $display("FAIL arst_hold: got bus %h flags %b required 0 1000", a_bus1, {s_ready1, out_state1, vec_valid1, res_valid1}); end
    @(posedge clk); #3 reset = 1'b1; clear_obs();
    new_stream();
    for (int i = 0; i < N; i++) begin bd_q.push_back(W'($urandom_range(0, 255))); bl_q.push_back(i == N - 1); end
    run_stream(0, H1, to);
    n_checks++; if (to || got_q.size() != 1 || rv_q.size() != 1) begin n_fail++; $display("FAIL arst_fresh_count: got %0d required 1", got_q.size()); end
    else begin
      n_checks++; if (got_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL arst_fresh_vector: got %h required %h", got_q[0], exp_q[0]); end
    end
  endtask

  task automatic test_random(input int rounds);
    bit to;
    int nb;
    for (int r = 0; r < rounds; r++) begin
      sel = 1'b0; reset_dut(); new_stream();
      nb = $urandom_range(20, 50);
      for (int i = 0; i < nb; i++) begin
        bd_q.push_back(W'($urandom_range(0, 255)));
        bl_q.push_back(i == nb - 1 || $urandom_range(0, 7) == 0);
      end
      run_stream(3, H1, to);
      n_checks++; if (to || got_q.size() != exp_q.size() || rv_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand%0d_count: got %0d required %0d", r, got_q.size(), exp_q.size()); end
      else begin
        for (int k = 0; k < exp_q.size(); k++) begin
          n_checks++; if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL rand%0d_vector%0d: got %h required %h", r, k, got_q[k], exp_q[k]); end
          n_checks++; if (vv_q[k] != exp_vv_q[k] || rv_q[k] != exp_vv_q[k] + H1) begin n_fail++; $display("FAIL rand%0d_timing%0d: got vv %0d rv %0d required %0d %0d", r, k, vv_q[k], rv_q[k], exp_vv_q[k], exp_vv_q[k] + H1); end
        end
      end
      n_checks++; if (len_cnt != exp_err || stab_err != 0) begin n_fail++; $display("FAIL rand%0d_flags: got len %0d stab %0d required %0d 0", r, len_cnt, stab_err, exp_err); end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    reset = 1'b1;
    #2;
    test_reset();
    test_basic();
    test_short_vector();
    test_back_to_back(1'b0);
    test_back_to_back(1'b1);
    test_missing_last();
    test_async_reset();
    test_random(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/act_vector_loader.md
Name: act_vector_loader

Overview:
- Producer-side feeder for the fully-connected node blocks.
- Accepts a serial stream of signed 8-bit activations over a valid/ready handshake and assembles each N_IN-element vector in a fill buffer.
- Presents the completed vector as a parallel bus (A0x..A14x order) to a layer of node blocks and holds it stable for the node pipeline latency.
- Raises a strobe on the cycle the node outputs reflect that vector. Double-buffered, so fill of vector k+1 overlaps hold of vector k.

Parameters:
- N_IN, 15, elements per vector (node fan-in).
- DATA_W, 8, activation width, two's complement.
- HOLD_CYCLES, 3, node latency: edges from bus change to node output valid (input reg, sum reg, ReLU reg).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- s_data  in  DATA_W  serial activation, signed.
- s_valid  in  1  s_data valid.
- s_last  in  1  marks final element of a vector.
- s_ready  out  1  loader can accept a beat.
- a_bus  out  N_IN*DATA_W  parallel vector; element i at bits [i*DATA_W +: DATA_W].
- vec_valid  out  1  one-cycle pulse: a_bus just changed to a new vector.
- res_valid  out  1  one-cycle pulse: node outputs now reflect current a_bus.
- len_err  out  1  one-cycle pulse: s_last position mismatched N_IN.

Behaviour:
- Reset (async assert, sync release): a_bus=0, vec_valid=0, res_valid=0, len_err=0, s_ready=1, fill index=0, fill buffer cleared, fill_full=0, hold counter=0. Reset mid-vector discards partial data; mid-hold drives a_bus to 0 immediately.
- Beat accepted on an edge where s_valid & s_ready. Element is written to fill[idx], then idx increments.
- s_ready = !fill_full. It is registered, with no combinational path from s_valid.
- Normal completion: beat with idx==N_IN-1 and s_last=1 sets fill_full and resets idx to 0.
- Early s_last (idx<N_IN-1): elements idx+1..N_IN-1 are zeroed, fill_full is set, and len_err pulses the next cycle.
- Missing s_last at idx==N_IN-1: the vector completes anyway, len_err pulses, and the next beat starts a new vector.
- Output side has two states:
  - IDLE (hold counter==0).
  - HOLD (counter>0).
- Swap: on an edge where fill_full=1 and the output is IDLE:
  - a_bus <= fill buffer.
  - fill_full <= 0.
  - counter <= HOLD_CYCLES.
  - vec_valid=1 for the following cycle.
- HOLD: the counter decrements each edge. res_valid=1 exactly HOLD_CYCLES cycles after the vec_valid cycle, for 1 cycle.
- a_bus is stable from the swap edge through the end of the res_valid cycle. The next swap occurs no earlier than the edge ending the res_valid cycle.
- Minimum vec_valid spacing is HOLD_CYCLES+1 cycles.
- Latency from acceptance of the last beat at edge e, with the output IDLE:
  - Swap at e+1; vec_valid high in cycle e+1..e+2.
  - res_valid high HOLD_CYCLES cycles later.
- Simultaneous events:
  - Fill completes on the same edge the counter reaches 0: swap on the next edge, since fill_full is registered.
  - Fill full while in HOLD: s_ready=0 and the stream stalls; no data is lost or overwritten.
- Back-to-back with continuous s_valid: throughput is one vector per max(N_IN+1, HOLD_CYCLES+1) cycles.
- No arithmetic: data passes bit-exact. Zero-pad uses 8'sd0.

Decomposition:
- Shared package holds:
  - DATA_W, N_IN, HOLD_CYCLES defaults.
  - Output-state enum (OUT_IDLE, OUT_HOLD).
  - Function packing an element index to a bus bit offset.
- One sub-module, act_hold_timer:
  - Loadable down-counter with load, busy, and expire pulse.
  - Produces res_valid and the swap-allowed signal.

Test Plan:
- Reset then stream 1..15 with s_last on 15 → s_ready low after beat 15. vec_valid 1 cycle later; a_bus element0=1, element14=15. res_valid exactly 3 cycles after vec_valid. len_err never set.
- Stream -128,127,-1 repeating with s_last on beat 3 → elements 3..14 = 0 and len_err pulses once. Elements 0..2 = -128,127,-1.
- Two vectors back-to-back, continuous s_valid → second vec_valid exactly 16 cycles after first. a_bus unchanged between first vec_valid and first res_valid.
- HOLD_CYCLES=20 build, two vectors streamed continuously → s_ready drops for the stall. Second vec_valid is 21 cycles after the first. Second vector intact.
- 15 beats with no s_last, then 15 beats with s_last → two vectors delivered, and len_err pulses once (first vector only).
- Assert reset asynchronously mid-fill (after beat 7) and again mid-hold → outputs zero without a clock edge. After release, a fresh 15-beat vector loads correctly.
